// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared sizes and helpers for the operand fetch stage
package operand_fetch_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [AW-1:0] X0 = '0;

  // True when the writeback bus carries the register being looked up this cycle.
  function automatic logic wb_hit(input logic en, input logic [AW-1:0] wa,
                                  input logic [AW-1:0] ra);
    return en && (wa == ra);
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// rtl/operand_scoreboard.sv - per-register pending bits for long-latency producers
module operand_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  output logic          rs1_pend,
  output logic          rs2_pend,
  output logic          rd_pend
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Set is applied after clear so a new load to the register being written back wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
    pend_d[X0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign rs1_pend = pend_q[rs1_addr];
  assign rs2_pend = pend_q[rs2_addr];
  assign rd_pend  = pend_q[rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - issue-stage operand read with writeback bypass and load scoreboard
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_wen,
  input  logic            id_long,
  output logic [AW-1:0]   ra_addr,
  input  logic [XLEN-1:0] ra_data,
  output logic [AW-1:0]   rb_addr,
  input  logic [XLEN-1:0] rb_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_rd_wen,
  output logic            ex_long
);

  logic            rs1_pend, rs2_pend, rd_pend;
  logic            rs1_hit, rs2_hit, rd_hit;
  logic            hazard, adv, transfer;
  logic [XLEN-1:0] rs1_sel, rs2_sel;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0] ex_rs2_val_q, ex_rs2_val_d;
  logic [AW-1:0]   ex_rd_q, ex_rd_d;
  logic            ex_rd_wen_q, ex_rd_wen_d;
  logic            ex_long_q, ex_long_d;

  assign ra_addr = id_rs1;
  assign rb_addr = id_rs2;

  operand_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (transfer && id_rd_wen && id_long && (id_rd != X0)),
    .set_addr (id_rd),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rs1_addr (id_rs1),
    .rs2_addr (id_rs2),
    .rd_addr  (id_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

  // A pending register whose writeback is on the bus this cycle is resolved by the bypass.
  always_comb begin
    rs1_hit = wb_hit(wb_en, wb_addr, id_rs1);
    rs2_hit = wb_hit(wb_en, wb_addr, id_rs2);
    rd_hit  = wb_hit(wb_en, wb_addr, id_rd);
    hazard  = (rs1_pend && (id_rs1 != X0) && !rs1_hit)
           || (rs2_pend && (id_rs2 != X0) && !rs2_hit)
           || (id_rd_wen && (id_rd != X0) && rd_pend && !rd_hit);
    adv      = !ex_valid_q || ex_ready;
    id_ready = adv && !hazard;
    transfer = id_valid && id_ready;
  end

  always_comb begin
    if (id_rs1 == X0)  rs1_sel = '0;
    else if (rs1_hit)  rs1_sel = wb_data;
    else               rs1_sel = ra_data;
    if (id_rs2 == X0)  rs2_sel = '0;
    else if (rs2_hit)  rs2_sel = wb_data;
    else               rs2_sel = rb_data;
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_wen_d  = ex_rd_wen_q;
    ex_long_d    = ex_long_q;
    if (adv) begin
      ex_valid_d = transfer;
      if (transfer) begin
        ex_rs1_val_d = rs1_sel;
        ex_rs2_val_d = rs2_sel;
        ex_rd_d      = id_rd;
        ex_rd_wen_d  = id_rd_wen;
        ex_long_d    = id_long;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_rd_q      <= '0;
      ex_rd_wen_q  <= 1'b0;
      ex_long_q    <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_wen_q  <= ex_rd_wen_d;
      ex_long_q    <= ex_long_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rd_wen  = ex_rd_wen_q;
  assign ex_long    = ex_long_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rd_wen, id_long;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen, ex_long;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_wen(id_rd_wen), .id_long(id_long),
    .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_long(ex_long)
  );

  // Register file model: asynchronous read, write at the edge.
  logic [31:0] rf [32];
  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];
  always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

  typedef struct {
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [4:0]  rd;
    logic        wen;
    logic        lng;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_op(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wb_en && wb_addr == rs) return wb_data;
    return rf[rs];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ex", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("ex_rs1_val", ex_rs1_val, e.rs1v);
          check_eq("ex_rs2_val", ex_rs2_val, e.rs2v);
          check_eq("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
          check_eq("ex_rd_wen", {31'd0, ex_rd_wen}, {31'd0, e.wen});
          check_eq("ex_long", {31'd0, ex_long}, {31'd0, e.lng});
        end
      end
      if (id_valid && id_ready) begin
        exp_t n;
        n.rs1v = model_op(id_rs1);
        n.rs2v = model_op(id_rs2);
        n.rd   = id_rd;
        n.wen  = id_rd_wen;
        n.lng  = id_long;
        exp_q.push_back(n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    wb(1'b1, a, d);
    step();
    wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wen, input logic lng);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_wen = wen; id_long = lng;
  endtask

  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic wen, input logic lng, output int waited);
    set_id(rs1, rs2, rd, wen, lng);
    waited = 0;
    @(negedge clk);
    while (!id_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check_eq("send_accept", {31'd0, id_ready}, 32'd1);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; ex_ready = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_wen = 0; id_long = 0;
    wb(1'b0, 5'd0, 32'd0);
    step(); step();
    check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_rs1_val", ex_rs1_val, 32'd0);
    check_eq("rst_rs2_val", ex_rs2_val, 32'd0);
    check_eq("rst_rd", {27'd0, ex_rd}, 32'd0);
    check_eq("rst_flags", {30'd0, ex_rd_wen, ex_long}, 32'd0);
    reset = 1'b0;
    id_rs1 = 5'd13; id_rs2 = 5'd17;
    #1;
    check_eq("ra_addr", {27'd0, ra_addr}, 32'd13);
    check_eq("rb_addr", {27'd0, rb_addr}, 32'd17);
    check_eq("idle_ready", {31'd0, id_ready}, 32'd1);

    // Basic read
    rf_write(5'd3, 32'h11); rf_write(5'd4, 32'h22);
    rf_write(5'd8, 32'h88); rf_write(5'd9, 32'h99); rf_write(5'd7, 32'h77);
    send(5'd3, 5'd4, 5'd1, 1'b1, 1'b0, w);
    check_eq("t1_latency", {31'd0, ex_valid}, 32'd1);
    check_eq("t1_rs1", ex_rs1_val, 32'h11);
    check_eq("t1_rs2", ex_rs2_val, 32'h22);

    // Same-cycle writeback bypass
    wb(1'b1, 5'd3, 32'hABCD);
    send(5'd3, 5'd4, 5'd2, 1'b1, 1'b0, w);
    wb(1'b0, 5'd0, 32'd0);
    check_eq("t2_bypass", ex_rs1_val, 32'hABCD);

    // Load-use stall released by the writeback
    send(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, w);
    set_id(5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_stall", {31'd0, id_ready}, 32'd0);
      @(posedge clk); #1;
    end
    wb(1'b1, 5'd5, 32'h55);
    send(5'd4, 5'd5, 5'd6, 1'b1, 1'b0, w);
    wb(1'b0, 5'd0, 32'd0);
    check_eq("t3_same_cycle", w, 0);
    check_eq("t3_rs2", ex_rs2_val, 32'h55);
    send(5'd5, 5'd5, 5'd5, 1'b1, 1'b0, w);
    check_eq("t3_pend_clear", w, 0);

    // Back-pressure
    step(); step();
    ex_ready = 1'b0;
    send(5'd8, 5'd9, 5'd10, 1'b1, 1'b0, w);
    set_id(5'd9, 5'd8, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t4_valid", {31'd0, ex_valid}, 32'd1);
      check_eq("t4_rs1", ex_rs1_val, 32'h88);
      check_eq("t4_rs2", ex_rs2_val, 32'h99);
      check_eq("t4_rd", {27'd0, ex_rd}, 32'd10);
      check_eq("t4_ready", {31'd0, id_ready}, 32'd0);
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    send(5'd9, 5'd8, 5'd11, 1'b1, 1'b0, w);
    check_eq("t4_release", w, 0);
    check_eq("t4_next_rs1", ex_rs1_val, 32'h99);

    // x0 handling
    rf_write(5'd0, 32'hFFFF_FFFF);
    wb(1'b1, 5'd0, 32'h1234);
    send(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, w);
    wb(1'b0, 5'd0, 32'd0);
    check_eq("t5_no_stall", w, 0);
    check_eq("t5_rs1_zero", ex_rs1_val, 32'd0);
    send(5'd0, 5'd3, 5'd0, 1'b1, 1'b1, w);
    check_eq("t5_x0_not_pend", w, 0);

    // Reset clears pending and the held instruction
    send(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, w);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6_ex_valid", {31'd0, ex_valid}, 32'd0);
    send(5'd7, 5'd7, 5'd12, 1'b1, 1'b0, w);
    check_eq("t6_no_stall", w, 0);
    check_eq("t6_rs1", ex_rs1_val, 32'h77);

    step(); step();
    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
